// File: rtl/param_updown_counter.sv
// Up/down counter with programmable modulus, parallel load, sticky over/underflow flags and terminal-count pulse.
// Latency: 1 cycle from sampled inputs to every output; no backpressure, a step is taken on every enabled edge.
module param_updown_counter #(
  parameter int               WIDTH       = 4,
  parameter bit               SATURATE    = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] max_value,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] counter_out,
  output logic             overflow_out,
  output logic             underflow_out,
  output logic             tc_out
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             tc_q, tc_d;

  always_comb begin
    count_d = count_q;
    // A boundary event in this cycle re-sets its flag after the clear below.
    ovf_d   = ovf_q & ~clear_flags;
    unf_d   = unf_q & ~clear_flags;
    tc_d    = 1'b0;
    if (load) begin
      count_d = (load_value > max_value) ? max_value : load_value;
    end else if (enable) begin
      if (up_down) begin
        if (count_q < max_value) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          count_d = SATURATE ? max_value : '0;
          ovf_d   = 1'b1;
          tc_d    = 1'b1;
        end
      end else begin
        // Counts above a lowered max_value still decrement normally.
        if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          count_d = SATURATE ? '0 : max_value;
          unf_d   = 1'b1;
          tc_d    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RESET_VALUE;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      tc_q    <= tc_d;
    end
  end

  assign counter_out   = count_q;
  assign overflow_out  = ovf_q;
  assign underflow_out = unf_q;
  assign tc_out        = tc_q;

endmodule
